game_status_counter: RTL and testbench

//  Upstream of color_mapper: owns the course timer, score and end-of-level flag.

---
 rtl/game_pkg.sv | 59 +++++
 rtl/hud_bin2bcd.sv | 63 ++++++
 rtl/game_status_counter.sv | 180 ++++++++++++++++++
 tb/tb_game_status_counter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the HUD game-status block.
// State encoding, keyboard scancodes and BCD helper functions.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSED,
        TALLY,
        DONE
    } game_state_t;

    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_JUMP  = 8'h26;

    // Double-dabble correction: add 3 to every BCD digit >= 5.
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int d = 0; d < 3; d++) begin
            if (r[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = r[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Combinational conversion, used only for constants.
    function automatic logic [11:0] bin2bcd(input logic [9:0] v);
        logic [21:0] sh;
        sh = {12'd0, v};
        for (int i = 0; i < 10; i++) begin
            sh = {dd_adjust(sh[21:10]), sh[9:0]} << 1;
        end
        return sh[21:10];
    endfunction

    // BCD decrement; a ones/tens digit of 0 borrows to 9. Zero stays zero.
    function automatic logic [11:0] bcd_dec(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        if (b != 12'd0) begin
            if (r[3:0] != 4'd0) begin
                r[3:0] = r[3:0] - 4'd1;
            end else begin
                r[3:0] = 4'd9;
                if (r[7:4] != 4'd0) begin
                    r[7:4] = r[7:4] - 4'd1;
                end else begin
                    r[7:4]  = 4'd9;
                    r[11:8] = r[11:8] - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hud_bin2bcd.sv
// Sequential double-dabble: 10-bit binary to 3 BCD digits.
// Ports: Clk, Reset (async high), load (restart with bin), bin[9:0],
//        bcd[11:0] (last finished result), busy (conversion in flight).
module hud_bin2bcd
    import game_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load,
    input  logic [9:0]  bin,
    output logic [11:0] bcd,
    output logic        busy
);

    logic [9:0]  sh_q, sh_d;
    logic [11:0] acc_q, acc_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    always_comb begin
        sh_d   = sh_q;
        acc_d  = acc_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load) begin
            // A new value aborts any conversion in flight.
            sh_d   = bin;
            acc_d  = 12'd0;
            cnt_d  = 4'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == 4'd10) begin
                bcd_d  = acc_q;
                busy_d = 1'b0;
            end else begin
                {acc_d, sh_d} = {dd_adjust(acc_q), sh_q} << 1;
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sh_q   <= '0;
            acc_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            acc_q  <= acc_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;

endmodule

// File: rtl/game_status_counter.sv
// Course timer, score and end-of-level flag feeding color_mapper and HUD.
// Ports: Clk, Reset (async high), frame_clk (vsync, sampled), start, pause,
//        level_clear, add_en/add_pts -> gameTime, score, time_bcd,
//        score_bcd, score_valid, endFlag, time_up, state_o.
module game_status_counter
    import game_pkg::*;
#(
    parameter int START_TIME      = 400,
    parameter int FRAMES_PER_TICK = 24,
    parameter int TALLY_PTS       = 1,
    parameter int SCORE_MAX       = 999
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        pause,
    input  logic        level_clear,
    input  logic        add_en,
    input  logic [9:0]  add_pts,
    output logic [9:0]  gameTime,
    output logic [9:0]  score,
    output logic [11:0] time_bcd,
    output logic [11:0] score_bcd,
    output logic        score_valid,
    output logic        endFlag,
    output logic        time_up,
    output logic [2:0]  state_o
);

    localparam int PW = $clog2(FRAMES_PER_TICK + 1);

    localparam logic [9:0]    START_BIN = 10'(START_TIME);
    localparam logic [11:0]   START_BCD = bin2bcd(START_BIN);
    localparam logic [PW-1:0] PS_LAST   = PW'(FRAMES_PER_TICK - 1);
    localparam logic [10:0]   TPTS      = 11'(TALLY_PTS);
    localparam logic [10:0]   SCAP      = 11'(SCORE_MAX);

    game_state_t state_q, state_d;
    logic [1:0]    fsync_q;
    logic          fprev_q;
    logic [9:0]    time_q, time_d;
    logic [11:0]   tbcd_q, tbcd_d;
    logic [9:0]    score_q, score_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tup_q, tup_d;

    logic        frame_tick;
    logic        load;
    logic        dec;
    logic        tally_inc;
    logic        add_ok;
    logic [10:0] sum;
    logic        bcd_busy;

    assign frame_tick = fsync_q[1] & ~fprev_q;

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        tbcd_d    = tbcd_q;
        score_d   = score_q;
        presc_d   = presc_q;
        tup_d     = tup_q;
        load      = 1'b0;
        dec       = 1'b0;
        tally_inc = 1'b0;
        add_ok    = add_en & ((state_q == RUN) | (state_q == TALLY));

        unique case (state_q)
            IDLE: begin
                load = start;
            end
            RUN: begin
                // level_clear wins over a tick that would end the course.
                if (level_clear) begin
                    state_d = TALLY;
                end else if (pause) begin
                    state_d = PAUSED;
                end else if (frame_tick) begin
                    if (presc_q == PS_LAST) begin
                        presc_d = '0;
                        dec     = 1'b1;
                        if (time_q <= 10'd1) begin
                            state_d = DONE;
                            tup_d   = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d = RUN;
                end
            end
            TALLY: begin
                if (time_q == 10'd0) begin
                    state_d = DONE;
                end else if (frame_tick) begin
                    dec       = 1'b1;
                    tally_inc = 1'b1;
                    if (time_q == 10'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                load = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (dec && (time_q != 10'd0)) begin
            time_d = time_q - 10'd1;
            tbcd_d = bcd_dec(tbcd_q);
        end

        // 11-bit sum cannot wrap: 999 + 1023 + tally points.
        sum = {1'b0, score_q}
            + (add_ok ? {1'b0, add_pts} : 11'd0)
            + (tally_inc ? TPTS : 11'd0);
        if (add_ok || tally_inc) begin
            score_d = (sum > SCAP) ? SCAP[9:0] : sum[9:0];
        end

        if (load) begin
            state_d = RUN;
            time_d  = START_BIN;
            tbcd_d  = START_BCD;
            score_d = 10'd0;
            presc_d = '0;
            tup_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            fsync_q <= '0;
            fprev_q <= 1'b0;
            time_q  <= '0;
            tbcd_q  <= '0;
            score_q <= '0;
            presc_q <= '0;
            tup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fsync_q <= {fsync_q[0], frame_clk};
            fprev_q <= fsync_q[1];
            time_q  <= time_d;
            tbcd_q  <= tbcd_d;
            score_q <= score_d;
            presc_q <= presc_d;
            tup_q   <= tup_d;
        end
    end

    // Converter restarts on the same edge the new score is registered.
    hud_bin2bcd u_bcd (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (score_d != score_q),
        .bin   (score_d),
        .bcd   (score_bcd),
        .busy  (bcd_busy)
    );

    assign gameTime    = time_q;
    assign score       = score_q;
    assign time_bcd    = tbcd_q;
    assign score_valid = ~bcd_busy;
    assign endFlag     = (state_q == DONE);
    assign time_up     = tup_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_game_status_counter.sv
// Self-checking bench for game_status_counter.
// Directed tables and sequences plus a randomized reference model.
module tb_game_status_counter;
    import game_pkg::*;

    localparam int ST   = 400;
    localparam int FPT  = 24;
    localparam int SMAX = 999;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        level_clear = 1'b0;
    logic        add_en = 1'b0;
    logic [9:0]  add_pts = '0;
    logic [9:0]  gameTime;
    logic [9:0]  score;
    logic [11:0] time_bcd;
    logic [11:0] score_bcd;
    logic        score_valid;
    logic        endFlag;
    logic        time_up;
    logic [2:0]  state_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] pts;
        int         exp_score;
    } addvec_t;

    addvec_t tbl [6];

    game_state_t m_state;
    int m_time, m_score, m_edges;
    bit m_tup, m_pause;

    always #5 Clk = ~Clk;

    game_status_counter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .start       (start),
        .pause       (pause),
        .level_clear (level_clear),
        .add_en      (add_en),
        .add_pts     (add_pts),
        .gameTime    (gameTime),
        .score       (score),
        .time_bcd    (time_bcd),
        .score_bcd   (score_bcd),
        .score_valid (score_valid),
        .endFlag     (endFlag),
        .time_up     (time_up),
        .state_o     (state_o)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            cyc();
            frame_clk = 1'b0;
            cyc();
        end
        cyc();
        cyc();
    endtask

    // Leaves the bench inside the cycle where the tick is presented.
    task automatic edge_to_tick();
        frame_clk = 1'b1;
        cyc();
        frame_clk = 1'b0;
        cyc();
    endtask

    task automatic start_p();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic add_p(input logic [9:0] p);
        add_pts = p;
        add_en = 1'b1;
        cyc();
        add_en = 1'b0;
        cyc();
    endtask

    task automatic clear_p();
        level_clear = 1'b1;
        cyc();
        level_clear = 1'b0;
        cyc();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !score_valid; i++) cyc();
        chk("score_valid_settle", score_valid, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_time"}, gameTime, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_tbcd"}, time_bcd, 0);
        chk({tag, "_sbcd"}, score_bcd, 0);
        chk({tag, "_valid"}, score_valid, 1);
        chk({tag, "_end"}, endFlag, 0);
        chk({tag, "_tup"}, time_up, 0);
        chk({tag, "_state"}, state_o, IDLE);
    endtask

    // Reference model: time is derived from edges counted while running.
    task automatic m_edge();
        if (m_state == RUN) begin
            m_edges++;
            m_time = ST - m_edges / FPT;
            if (m_time <= 0) begin
                m_time  = 0;
                m_state = DONE;
                m_tup   = 1'b1;
            end
        end else if (m_state == TALLY) begin
            if (m_time > 0) begin
                m_time--;
                m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
            end
            if (m_time == 0) m_state = DONE;
        end
    endtask

    task automatic m_compare();
        chk("rnd_time", gameTime, m_time);
        chk("rnd_tbcd", time_bcd, to_bcd(m_time));
        chk("rnd_score", score, m_score);
        chk("rnd_state", state_o, m_state);
        chk("rnd_end", endFlag, m_state == DONE);
        chk("rnd_tup", time_up, m_tup);
        wait_valid();
        chk("rnd_sbcd", score_bcd, to_bcd(m_score));
    endtask

    initial begin
        int prev, n, r, p;
        bit low;

        tbl[0] = '{10'd100,  100};
        tbl[1] = '{10'd500,  600};
        tbl[2] = '{10'd390,  990};
        tbl[3] = '{10'd25,   999};
        tbl[4] = '{10'd0,    999};
        tbl[5] = '{10'd1023, 999};

        #1 Reset = 1'b1;
        cyc();
        cyc();
        chk_reset_vals("rst0");
        Reset = 1'b0;
        cyc();

        // Run A: start, score table, 1-unit decrement, pause, async reset.
        start_p();
        chk("a_state", state_o, RUN);
        chk("a_time", gameTime, ST);
        chk("a_tbcd", time_bcd, 12'h400);
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            add_pts = tbl[i].pts;
            add_en = 1'b1;
            cyc();
            add_en = 1'b0;
            low = !score_valid;
            n = 0;
            while (!score_valid && n < 20) begin
                cyc();
                n++;
            end
            chk("tbl_valid_drop", low, tbl[i].exp_score != prev);
            chk("tbl_bcd_lat", n <= 12, 1);
            chk("tbl_score", score, tbl[i].exp_score);
            chk("tbl_sbcd", score_bcd, to_bcd(tbl[i].exp_score));
            prev = tbl[i].exp_score;
        end
        edges(FPT - 1);
        chk("a_time_23", gameTime, 400);
        edges(1);
        chk("a_time_399", gameTime, 399);
        chk("a_tbcd_399", time_bcd, 12'h399);
        edges(99 * FPT);
        chk("a_time_300", gameTime, 300);
        edges(10);
        pause = 1'b1;
        cyc();
        cyc();
        chk("a_paused", state_o, PAUSED);
        add_p(10'd5);
        chk("a_pause_add", score, 999 - 0);
        edges(50);
        chk("a_pause_hold", gameTime, 300);
        pause = 1'b0;
        cyc();
        cyc();
        chk("a_resume", state_o, RUN);
        edges(13);
        chk("a_resume_13", gameTime, 300);
        edges(1);
        chk("a_resume_14", gameTime, 299);
        edges(176 * FPT);
        chk("a_time_123", gameTime, 123);
        chk("a_tbcd_123", time_bcd, 12'h123);
        Reset = 1'b1;
        #2;
        chk_reset_vals("rst_async");
        cyc();
        Reset = 1'b0;
        cyc();

        // Run B: full timeout.
        start_p();
        edges(ST * FPT - 1);
        chk("b_time_1", gameTime, 1);
        chk("b_end_early", endFlag, 0);
        edges(1);
        chk("b_time_0", gameTime, 0);
        chk("b_tbcd_0", time_bcd, 0);
        chk("b_end", endFlag, 1);
        chk("b_tup", time_up, 1);
        chk("b_state", state_o, DONE);
        edges(5);
        chk("b_floor", gameTime, 0);
        add_p(10'd5);
        chk("b_done_add", score, 0);

        // Run C: level clear with time 5, score 100.
        start_p();
        chk("c_tup_clr", time_up, 0);
        chk("c_time", gameTime, ST);
        add_p(10'd100);
        wait_valid();
        edges(395 * FPT);
        chk("c_time_5", gameTime, 5);
        clear_p();
        chk("c_tally", state_o, TALLY);
        edges(4);
        chk("c_time_1", gameTime, 1);
        chk("c_score_104", score, 104);
        edges(1);
        chk("c_time_0", gameTime, 0);
        chk("c_score", score, 105);
        chk("c_end", endFlag, 1);
        chk("c_tup", time_up, 0);
        wait_valid();
        chk("c_sbcd", score_bcd, 12'h105);

        // Run D: level clear collides with the zeroing tick.
        start_p();
        edges(ST * FPT - 1);
        chk("d_time_1", gameTime, 1);
        edge_to_tick();
        level_clear = 1'b1;
        cyc();
        level_clear = 1'b0;
        cyc();
        chk("d_tally", state_o, TALLY);
        chk("d_time", gameTime, 1);
        chk("d_tup", time_up, 0);
        add_p(10'd30);
        chk("d_add", score, 30);
        edge_to_tick();
        add_pts = 10'd20;
        add_en = 1'b1;
        cyc();
        add_en = 1'b0;
        cyc();
        chk("d_sum", score, 51);
        chk("d_time_0", gameTime, 0);
        chk("d_done", state_o, DONE);
        chk("d_tup_0", time_up, 0);

        // Randomized operations against the reference model.
        m_state = DONE;
        m_time = 0;
        m_score = 51;
        m_edges = 0;
        m_tup = 1'b0;
        m_pause = 1'b0;
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (k == 0 || (r >= 85 && r < 92)) begin
                if (m_state == IDLE || m_state == DONE) begin
                    m_state = m_pause ? PAUSED : RUN;
                    m_time = ST;
                    m_score = 0;
                    m_edges = 0;
                    m_tup = 1'b0;
                end
                start_p();
            end else if (r < 55) begin
                n = $urandom_range(1, 12);
                for (int j = 0; j < n; j++) m_edge();
                edges(n);
            end else if (r < 70) begin
                p = $urandom_range(0, 1023);
                if (m_state == RUN || m_state == TALLY)
                    m_score = (m_score + p > SMAX) ? SMAX : m_score + p;
                add_p(10'(p));
            end else if (r < 80) begin
                m_pause = !m_pause;
                if (m_pause && m_state == RUN) m_state = PAUSED;
                if (!m_pause && m_state == PAUSED) m_state = RUN;
                pause = m_pause;
                cyc();
                cyc();
            end else if (r < 85) begin
                if (m_state == RUN) m_state = TALLY;
                clear_p();
            end else begin
                cyc();
                cyc();
            end
            m_compare();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
